fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the async FIFO among NUM_REQ requesters in the write clock domain.
- Grants one requester at a time for a bounded burst of up to BURST_LEN words.
- Drives the FIFO's w_en/wdata and honours w_full backpressure.
- Acknowledges each accepted word back to the owning requester.

---
 rtl/fifo_wr_arbiter.sv | 91 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for the async FIFO write port; FIFO_WR_ARB_STATS_EN adds per-requester write counters
module fifo_wr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_IDX_W    = 2,
  parameter int MEMORY_WIDTH = 4,
  parameter int BURST_LEN    = 4,
  parameter int BURST_CNT_W  = 3
) (
  input  logic                            w_clk,
  input  logic                            wrst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*MEMORY_WIDTH-1:0] req_data,
  input  logic                            w_full,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic                            stats_clr,
  output logic [NUM_REQ*8-1:0]            wr_count,
`endif
  output logic [NUM_REQ-1:0]              gnt,
  output logic [REQ_IDX_W-1:0]            gnt_idx,
  output logic                            busy,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            w_en,
  output logic [MEMORY_WIDTH-1:0]         wdata
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [REQ_IDX_W-1:0]   owner_q, owner_d, last_q, last_d, pick, idx;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   wr, rel, start;
  always_comb begin
    pick = last_q;
    idx  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = REQ_IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (req[idx]) pick = idx;
    end
  end
  always_comb begin
    start = state_q == IDLE && |req;
    wr    = state_q == GRANT && req[owner_q] && !w_full;
    rel   = state_q == GRANT && (!req[owner_q] || (wr && burst_cnt_q == BURST_CNT_W'(BURST_LEN - 1)));
    w_en  = wr;
    wdata = state_q == GRANT ? req_data[owner_q*MEMORY_WIDTH +: MEMORY_WIDTH] : '0;
    ack   = '0;
    ack[owner_q] = wr;
  end
  always_comb begin
    state_d     = start ? GRANT : rel ? IDLE : state_q;
    owner_d     = start ? pick : owner_q;
    last_d      = rel ? owner_q : last_q;
    burst_cnt_d = state_q == IDLE ? '0 : burst_cnt_q + BURST_CNT_W'(wr);
    gnt_d       = rel ? '0 : gnt_q;
    if (start) begin
      gnt_d       = '0;
      gnt_d[pick] = 1'b1;
    end
  end
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      last_q      <= REQ_IDX_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
  assign gnt     = gnt_q;
  assign gnt_idx = owner_q;
  assign busy    = state_q == GRANT;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*8-1:0] wr_count_q, wr_count_d;
  always_comb begin
    wr_count_d = wr_count_q;
    for (int k = 0; k < NUM_REQ; k++)
      wr_count_d[k*8 +: 8] = stats_clr ? 8'd0 :
        wr_count_q[k*8 +: 8] + 8'(ack[k] && wr_count_q[k*8 +: 8] != 8'hff);
  end
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) wr_count_q <= '0;
    else wr_count_q <= wr_count_d;
  end
  assign wr_count = wr_count_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of fifo_wr_arbiter against a word-queue reference model
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 4, B = 4;
  logic w_clk = 1'b0, wrst_n = 1'b0, w_full = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] gnt, ack;
  logic [1:0] gnt_idx;
  logic busy, w_en;
  logic [W-1:0] wdata;
`ifdef FIFO_WR_ARB_STATS_EN
  logic stats_clr = 1'b0;
  logic [N*8-1:0] wr_count;
`endif
  fifo_wr_arbiter #(.NUM_REQ(N), .REQ_IDX_W(2), .MEMORY_WIDTH(W), .BURST_LEN(B), .BURST_CNT_W(3)) dut (
    .w_clk(w_clk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .w_full(w_full),
`ifdef FIFO_WR_ARB_STATS_EN
    .stats_clr(stats_clr), .wr_count(wr_count),
`endif
    .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .ack(ack), .w_en(w_en), .wdata(wdata));
  always #5 w_clk = ~w_clk;
  int checks = 0, passes = 0;
  logic [W-1:0] q[N][$];
  int glog[$], wlog[$];
  int m_busy, m_owner, m_last, m_words;
  int m_cnt[N];
  bit m_wr;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_words = 0;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
  endtask
  // called at posedge+1; the reset pulse ends before the next falling edge
  task automatic pulse_reset(input int ns_low);
    wrst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_en", w_en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_gnt_idx", gnt_idx, 0);
    #(ns_low - 1);
    wrst_n = 1'b1;
    model_reset();
  endtask
  task automatic cyc(input bit full);
    logic [63:0] eg, ea, ed;
    w_full = full;
    for (int k = 0; k < N; k++) begin
      req[k] = q[k].size() > 0;
      req_data[k*W +: W] = req[k] ? q[k][0] : W'($urandom);
    end
    @(negedge w_clk);
    m_wr = m_busy != 0 && req[m_owner] && !w_full;
    eg = m_busy != 0 ? 64'(1) << m_owner : 0;
    ea = m_wr ? 64'(1) << m_owner : 0;
    ed = m_busy != 0 ? 64'(req_data[m_owner*W +: W]) : 0;
    chk("gnt", gnt, eg);
    chk("busy", busy, 64'(m_busy != 0));
    chk("w_en", w_en, 64'(m_wr));
    chk("ack", ack, ea);
    chk("wdata", wdata, ed);
    if (m_busy != 0) chk("gnt_idx", gnt_idx, 64'(m_owner));
`ifdef FIFO_WR_ARB_STATS_EN
    for (int k = 0; k < N; k++) chk("wr_count", wr_count[k*8 +: 8], 64'(m_cnt[k]));
`endif
    @(posedge w_clk);
`ifdef FIFO_WR_ARB_STATS_EN
    if (stats_clr) for (int k = 0; k < N; k++) m_cnt[k] = 0;
    else if (m_wr && m_cnt[m_owner] < 255) m_cnt[m_owner]++;
`endif
    if (m_busy == 0) begin
      if (|req) begin
        for (int i = 1; i <= N; i++)
          if (req[(m_last + i) % N]) begin m_owner = (m_last + i) % N; break; end
        m_busy = 1; m_words = 0;
        glog.push_back(m_owner);
      end
    end else begin
      if (m_wr) begin
        wlog.push_back(int'(q[m_owner].pop_front()));
        m_words++;
      end
      if ((m_wr && m_words == B) || !req[m_owner]) begin m_busy = 0; m_last = m_owner; end
    end
    #1;
  endtask
  function automatic int pending();
    int p = m_busy;
    for (int k = 0; k < N; k++) p += q[k].size();
    return p;
  endfunction
  task automatic drain(input string tag, input int bound);
    int n = 0;
    while (pending() != 0 && n < bound) begin cyc(1'b0); n++; end
    chk(tag, 64'(pending()), 0);
  endtask
  task automatic start_test();
    glog.delete(); wlog.delete();
    for (int k = 0; k < N; k++) q[k].delete();
    pulse_reset(3);
  endtask
  initial begin
    logic [W-1:0] saved[$];
    model_reset();
    @(posedge w_clk); #1;
    // single requester: two bursts of 4 and 2 words
    start_test();
    for (int i = 1; i <= 6; i++) q[0].push_back(W'(i));
    drain("t1_drain", 40);
    chk("t1_ngrants", glog.size(), 2);
    chk("t1_g0", glog[0], 0);
    chk("t1_g1", glog[1], 0);
    chk("t1_nwords", wlog.size(), 6);
    for (int i = 0; i < 6; i++) chk("t1_word", wlog[i], i + 1);
    // all requesting: strict rotation, full bursts
    start_test();
    for (int k = 0; k < N; k++) for (int i = 0; i < 8; i++) q[k].push_back(W'($urandom));
    drain("t2_drain", 80);
    chk("t2_ngrants", glog.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_order", glog[i], i % N);
    // stall mid-burst on w_full
    start_test();
    for (int i = 0; i < 4; i++) q[2].push_back(W'(i + 9));
    saved = q[2];
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    chk("t3_pre", wlog.size(), 2);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1);
      chk("t3_stall_gnt", gnt, 4'b0100);
    end
    chk("t3_stalled", wlog.size(), 2);
    drain("t3_drain", 20);
    chk("t3_ngrants", glog.size(), 1);
    for (int i = 0; i < 4; i++) chk("t3_word", wlog[i], saved[i]);
    // owner drops req early; next owner is the next requester after it
    start_test();
    for (int i = 0; i < 2; i++) begin q[1].push_back(W'(i + 3)); q[3].push_back(W'(i + 7)); end
    drain("t4_drain", 20);
    chk("t4_ngrants", glog.size(), 2);
    chk("t4_g0", glog[0], 1);
    chk("t4_g1", glog[1], 3);
    // asynchronous reset mid-burst restores requester 0 priority
    start_test();
    for (int i = 0; i < 6; i++) q[1].push_back(W'($urandom));
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    chk("t5_pre", wlog.size(), 2);
    for (int i = 0; i < 3; i++) q[0].push_back(W'($urandom));
    pulse_reset(3);
    drain("t5_drain", 40);
    chk("t5_ngrants", glog.size(), 3);
    chk("t5_g0", glog[0], 1);
    chk("t5_g1", glog[1], 0);
    chk("t5_g2", glog[2], 1);
    chk("t5_nwords", wlog.size(), 9);
    // randomized traffic with backpressure
    start_test();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0)
          for (int i = 0; i < int'($urandom_range(1, 5)); i++) q[k].push_back(W'($urandom));
`ifdef FIFO_WR_ARB_STATS_EN
      stats_clr = $urandom_range(0, 31) == 0;
`endif
      cyc($urandom_range(0, 3) == 0);
    end
`ifdef FIFO_WR_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    drain("t6_drain", 400);
`ifdef FIFO_WR_ARB_STATS_EN
    // counter saturation and synchronous clear
    start_test();
    for (int i = 0; i < 300; i++) q[2].push_back(W'($urandom));
    drain("t7_drain", 500);
    chk("t7_sat", wr_count[2*8 +: 8], 255);
    stats_clr = 1'b1;
    cyc(1'b0);
    stats_clr = 1'b0;
    chk("t7_clr", wr_count[2*8 +: 8], 0);
    cyc(1'b0);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
